// File: rtl/monopulse_pkg.sv
// Shared types and sizing helpers for the monopulse ratio unit.
// Optional rounding build: define MONOPULSE_ROUND_EN.
package monopulse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DIV,
      STORE,
      DONE
   } state_t;

   // Dividend width: error magnitude with the fractional bits appended.
   function automatic int div_bits(input int data_size, input int frac_bits);
      return data_size + frac_bits;
   endfunction

   // Iteration counter must hold D+1 when the guard bit is enabled.
   function automatic int cnt_width(input int d);
      return $clog2(d + 2);
   endfunction

   function automatic logic [127:0] max_mag(input int width);
      return (128'd1 << (width - 1)) - 128'd1;
   endfunction

endpackage

// File: rtl/monopulse_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// The divisor must stay stable for the whole run after i_start.
module monopulse_seq_divider #(
   parameter int DIVIDEND_W = 80,
   parameter int DIVISOR_W  = 64,
   parameter int CNT_W      = 7
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [DIVIDEND_W-1:0] i_dividend,
   input  logic [DIVISOR_W-1:0]  i_divisor,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DIVIDEND_W-1:0] o_quotient
);

   logic [DIVIDEND_W-1:0] work;
   logic [DIVISOR_W-1:0]  remainder;
   logic [CNT_W-1:0]      count;
   logic [DIVISOR_W:0]    trial;
   logic [DIVISOR_W-1:0]  diff;
   logic                  take;

   // The remainder is always below the divisor, so the difference fits in DIVISOR_W bits.
   always_comb begin
      trial = {remainder, work[DIVIDEND_W-1]};
      diff  = trial[DIVISOR_W-1:0] - i_divisor;
      take  = (trial >= {1'b0, i_divisor});
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         work      <= '0;
         remainder <= '0;
         count     <= '0;
      end else if (i_start) begin
         work      <= i_dividend;
         remainder <= '0;
         count     <= CNT_W'(DIVIDEND_W);
      end else if (count != '0) begin
         remainder <= take ? diff : trial[DIVISOR_W-1:0];
         work      <= {work[DIVIDEND_W-2:0], take};
         count     <= count - CNT_W'(1);
      end
   end

   assign o_busy     = (count != '0);
   assign o_done     = (count == CNT_W'(1));
   assign o_quotient = work;

endmodule

// File: rtl/monopulse_ratio.sv
// Multi-channel signed ratio error/reference through one shared sequential divider.
// MONOPULSE_ROUND_EN adds a guard quotient bit and rounds half away from zero.
module monopulse_ratio
   import monopulse_pkg::*;
#(
   parameter int DATA_SIZE = 64,
   parameter int FRAC_BITS = 16,
   parameter int NUM_CH    = 2
) (
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [DATA_SIZE-1:0]        i_reference,
   input  logic [NUM_CH*DATA_SIZE-1:0] i_error,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [NUM_CH*DATA_SIZE-1:0] o_ratio,
   output logic [NUM_CH-1:0]           o_div_zero,
   output logic [NUM_CH-1:0]           o_saturated
);

   localparam int D = div_bits(DATA_SIZE, FRAC_BITS);
`ifdef MONOPULSE_ROUND_EN
   localparam int ITER = D + 1;
`else
   localparam int ITER = D;
`endif
   localparam int CNT_W = cnt_width(D);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [DATA_SIZE-1:0] MAX_MAG = DATA_SIZE'(max_mag(DATA_SIZE));
   localparam logic [CH_W-1:0]      LAST_CH = CH_W'(NUM_CH - 1);

   state_t                state, state_next;
   logic [CH_W-1:0]       ch;
   logic [DATA_SIZE-1:0]  ref_mag;
   logic                  ref_sign;
   logic [DATA_SIZE-1:0]  err_mag [NUM_CH];
   logic [NUM_CH-1:0]     err_sign;
   logic [DATA_SIZE-1:0]  ratio [NUM_CH];
   logic [NUM_CH-1:0]     div_zero, saturated;

   logic                  div_start, div_busy, div_done;
   logic [ITER-1:0]       div_dividend, div_quotient;

   logic [DATA_SIZE-1:0]  err_sel, mag_sel;
   logic [ITER:0]         mag_wide;
   logic                  sign_sel, dz_now, sat_now;

   function automatic logic [DATA_SIZE-1:0] magnitude(input logic [DATA_SIZE-1:0] x);
      return x[DATA_SIZE-1] ? -x : x;
   endfunction

   always_ff @(posedge i_clock) begin
      if (i_reset) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      div_start  = 1'b0;
      case (state)
         IDLE:    if (i_valid) state_next = LOAD;
         LOAD: begin
            div_start  = 1'b1;
            state_next = DIV;
         end
         DIV:     if (div_done || !div_busy) state_next = STORE;
         STORE:   state_next = (ch == LAST_CH) ? DONE : LOAD;
         DONE:    if (i_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign o_ready = (state == IDLE);
   assign o_valid = (state == DONE);

   assign err_sel      = err_mag[ch];
   assign div_dividend = ITER'({err_sel, {FRAC_BITS{1'b0}}}) << (ITER - D);

   // Zero reference overrides the quotient; otherwise clamp symmetrically to +/-MAX.
   always_comb begin
`ifdef MONOPULSE_ROUND_EN
      mag_wide = {2'b00, div_quotient[ITER-1:1]} + {{ITER{1'b0}}, div_quotient[0]};
`else
      mag_wide = {1'b0, div_quotient};
`endif
      dz_now   = 1'b0;
      sat_now  = 1'b0;
      mag_sel  = '0;
      sign_sel = err_sign[ch];
      if (ref_mag == '0) begin
         dz_now  = 1'b1;
         mag_sel = (err_sel == '0) ? '0 : MAX_MAG;
      end else begin
         sat_now  = (mag_wide > {{(ITER+1-DATA_SIZE){1'b0}}, MAX_MAG});
         mag_sel  = sat_now ? MAX_MAG : mag_wide[DATA_SIZE-1:0];
         sign_sel = err_sign[ch] ^ ref_sign;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         ch        <= '0;
         ref_mag   <= '0;
         ref_sign  <= 1'b0;
         err_sign  <= '0;
         div_zero  <= '0;
         saturated <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            err_mag[c] <= '0;
            ratio[c]   <= '0;
         end
      end else begin
         case (state)
            IDLE: if (i_valid) begin
               ch        <= '0;
               ref_mag   <= magnitude(i_reference);
               ref_sign  <= i_reference[DATA_SIZE-1];
               div_zero  <= '0;
               saturated <= '0;
               for (int c = 0; c < NUM_CH; c++) begin
                  err_mag[c]  <= magnitude(i_error[c*DATA_SIZE +: DATA_SIZE]);
                  err_sign[c] <= i_error[c*DATA_SIZE + DATA_SIZE - 1];
               end
            end
            STORE: begin
               ratio[ch]     <= sign_sel ? -mag_sel : mag_sel;
               div_zero[ch]  <= dz_now;
               saturated[ch] <= sat_now;
               if (ch != LAST_CH) ch <= ch + CH_W'(1);
            end
            default: ;
         endcase
      end
   end

   monopulse_seq_divider #(
      .DIVIDEND_W (ITER),
      .DIVISOR_W  (DATA_SIZE),
      .CNT_W      (CNT_W)
   ) u_divider (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_start    (div_start),
      .i_dividend (div_dividend),
      .i_divisor  (ref_mag),
      .o_busy     (div_busy),
      .o_done     (div_done),
      .o_quotient (div_quotient)
   );

   for (genvar c = 0; c < NUM_CH; c++) begin : g_out
      assign o_ratio[c*DATA_SIZE +: DATA_SIZE] = ratio[c];
   end
   assign o_div_zero  = div_zero;
   assign o_saturated = saturated;

endmodule

// File: tb/tb_monopulse_ratio.sv
// Self-checking bench for monopulse_ratio against an arithmetic reference model.
// Honours MONOPULSE_ROUND_EN for expected rounding and latency.
module tb_monopulse_ratio;

   localparam int DS = 16;
   localparam int FB = 8;
   localparam int NC = 2;
   localparam int D  = DS + FB;
`ifdef MONOPULSE_ROUND_EN
   localparam int LAT = NC * (D + 3);
`else
   localparam int LAT = NC * (D + 2);
`endif
   localparam longint MAXV = 32767;

   localparam int NDIR = 5;
   localparam logic [15:0] TR  [NDIR] = '{16'd4, 16'd0, 16'd1,    16'h8000, 16'd3};
   localparam logic [15:0] TE0 [NDIR] = '{16'd2, 16'd5, 16'd200,  16'h8000, 16'd2};
   localparam logic [15:0] TE1 [NDIR] = '{16'hFFFD, 16'd0, 16'hFF38, 16'd7, 16'd1};

   logic             i_clock = 1'b0;
   logic             i_reset = 1'b1;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [DS-1:0]    i_reference = '0;
   logic [NC*DS-1:0] i_error = '0;
   logic             o_valid;
   logic             i_ready = 1'b0;
   logic [NC*DS-1:0] o_ratio;
   logic [NC-1:0]    o_div_zero;
   logic [NC-1:0]    o_saturated;

   int passed = 0;
   int total  = 0;

   always #5 i_clock = ~i_clock;

   monopulse_ratio #(
      .DATA_SIZE (DS),
      .FRAC_BITS (FB),
      .NUM_CH    (NC)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_reference (i_reference),
      .i_error     (i_error),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_ratio     (o_ratio),
      .o_div_zero  (o_div_zero),
      .o_saturated (o_saturated)
   );

   // Ratio from real-number rules: scale, divide, round or truncate magnitude, clamp, re-sign.
   task automatic ref_model(input logic signed [15:0] r, input logic signed [15:0] e,
                            output logic [15:0] rat, output logic dz, output logic sat);
      longint rv, ev, ar, ae, num, mag;
      bit     neg;
      rv = r;
      ev = e;
      ar = (rv < 0) ? -rv : rv;
      ae = (ev < 0) ? -ev : ev;
      dz = 1'b0;
      sat = 1'b0;
      if (ar == 0) begin
         dz  = 1'b1;
         mag = (ae == 0) ? 0 : MAXV;
         neg = (ev < 0);
      end else begin
         num = ae * (64'sd1 << FB);
`ifdef MONOPULSE_ROUND_EN
         mag = (2 * num + ar) / (2 * ar);
`else
         mag = num / ar;
`endif
         if (mag > MAXV) begin
            mag = MAXV;
            sat = 1'b1;
         end
         neg = (ev < 0) != (rv < 0);
      end
      rat = neg ? 16'(-mag) : 16'(mag);
   endtask

   task automatic applyStimulus(input logic [15:0] r, input logic [15:0] e0,
                                input logic [15:0] e1, output int lat);
      int guard;
      lat = -1;
      @(negedge i_clock);
      guard = 0;
      while (!o_ready && guard < 300) begin
         @(negedge i_clock);
         guard++;
      end
      i_reference = r;
      i_error     = {e1, e0};
      i_valid     = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      i_valid     = 1'b0;
      i_reference = 16'($urandom);
      i_error     = $urandom;
      for (int n = 1; n <= 300; n++) begin
         @(posedge i_clock);
         @(negedge i_clock);
         if (o_valid) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic releaseResult();
      i_ready = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      i_ready = 1'b0;
   endtask

   function automatic logic [15:0] pick_value();
      case ($urandom_range(0, 5))
         0:       return 16'd0;
         1:       return 16'h8000;
         2:       return 16'($signed(5'($urandom_range(0, 16)) - 5'sd8));
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      logic seen_accept;
      i_reset     = 1'b1;
      i_valid     = 1'b1;
      i_reference = 16'd4;
      i_error     = {16'd1, 16'd2};
      repeat (3) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b0;
      i_valid = 1'b0;
      total++;
      if ({o_ready, o_valid, o_ratio, o_div_zero, o_saturated} !== {1'b1, 1'b0, 36'd0})
         $display("[TB] FAIL reset_state: got rdy=%b vld=%b ratio=%h dz=%b sat=%b want rdy=1 vld=0 ratio=0 dz=0 sat=0",
                  o_ready, o_valid, o_ratio, o_div_zero, o_saturated);
      else passed++;
      seen_accept = 1'b0;
      repeat (5) begin
         @(posedge i_clock);
         @(negedge i_clock);
         if (!o_ready || o_valid) seen_accept = 1'b1;
      end
      total++;
      if (seen_accept !== 1'b0)
         $display("[TB] FAIL reset_drops_sample: got busy=%b want busy=0", seen_accept);
      else passed++;
   endtask

   task automatic test_directed();
      int lat;
      logic [15:0] x0, x1;
      logic dz0, dz1, s0, s1;
      for (int i = 0; i < NDIR; i++) begin
         applyStimulus(TR[i], TE0[i], TE1[i], lat);
         ref_model(TR[i], TE0[i], x0, dz0, s0);
         ref_model(TR[i], TE1[i], x1, dz1, s1);
         total++;
         if (lat !== LAT) $display("[TB] FAIL latency case%0d: got %0d want %0d", i, lat, LAT);
         else passed++;
         total++;
         if (o_ratio !== {x1, x0})
            $display("[TB] FAIL ratio case%0d: got %h want %h", i, o_ratio, {x1, x0});
         else passed++;
         total++;
         if ({o_div_zero, o_saturated} !== {dz1, dz0, s1, s0})
            $display("[TB] FAIL flags case%0d: got dz=%b sat=%b want dz=%b sat=%b",
                     i, o_div_zero, o_saturated, {dz1, dz0}, {s1, s0});
         else passed++;
         releaseResult();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [15:0] r, e0, e1, x0, x1;
      logic dz0, dz1, s0, s1;
      logic [38:0] want;
      r  = 16'($urandom_range(1, 40));
      e0 = 16'($urandom);
      e1 = 16'($urandom_range(0, 50));
      applyStimulus(r, e0, e1, lat);
      ref_model(r, e0, x0, dz0, s0);
      ref_model(r, e1, x1, dz1, s1);
      want = {1'b1, 1'b0, x1, x0, dz1, dz0, s1, s0};
      for (int n = 0; n < 10; n++) begin
         i_valid     = n[0];
         i_reference = 16'($urandom);
         i_error     = $urandom;
         @(posedge i_clock);
         @(negedge i_clock);
         total++;
         if ({o_valid, o_ready, o_ratio, o_div_zero, o_saturated} !== want)
            $display("[TB] FAIL hold_cycle%0d: got %h want %h", n,
                     {o_valid, o_ready, o_ratio, o_div_zero, o_saturated}, want);
         else passed++;
      end
      i_valid = 1'b0;
      releaseResult();
      total++;
      if ({o_valid, o_ready} !== 2'b01)
         $display("[TB] FAIL release: got vld=%b rdy=%b want vld=0 rdy=1", o_valid, o_ready);
      else passed++;
      @(posedge i_clock);
      @(negedge i_clock);
      total++;
      if (o_ready !== 1'b1)
         $display("[TB] FAIL ignored_sample: got rdy=%b want rdy=1", o_ready);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic seen;
      logic [15:0] e1, x0, x1;
      logic dz0, dz1, s0, s1;
      @(negedge i_clock);
      i_reference = 16'd4;
      i_error     = {16'd9, 16'd2};
      i_valid     = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      i_valid = 1'b0;
      repeat (19) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b0;
      total++;
      if ({o_ready, o_valid, o_ratio, o_div_zero, o_saturated} !== {1'b1, 1'b0, 36'd0})
         $display("[TB] FAIL abort_state: got rdy=%b vld=%b ratio=%h dz=%b sat=%b want rdy=1 vld=0 ratio=0 dz=0 sat=0",
                  o_ready, o_valid, o_ratio, o_div_zero, o_saturated);
      else passed++;
      seen = 1'b0;
      repeat (60) begin
         @(posedge i_clock);
         @(negedge i_clock);
         if (o_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) $display("[TB] FAIL abort_no_valid: got seen=%b want seen=0", seen);
      else passed++;
      e1 = 16'($urandom);
      applyStimulus(16'd4, 16'd2, e1, lat);
      ref_model(16'd4, 16'd2, x0, dz0, s0);
      ref_model(16'd4, e1, x1, dz1, s1);
      total++;
      if ({lat, o_ratio} !== {LAT, x1, x0})
         $display("[TB] FAIL after_abort: got lat=%0d ratio=%h want lat=%0d ratio=%h",
                  lat, o_ratio, LAT, {x1, x0});
      else passed++;
      releaseResult();
   endtask

   task automatic test_random();
      int lat;
      logic [15:0] r, e0, e1, x0, x1;
      logic dz0, dz1, s0, s1;
      for (int i = 0; i < 25; i++) begin
         r  = pick_value();
         e0 = pick_value();
         e1 = pick_value();
         applyStimulus(r, e0, e1, lat);
         ref_model(r, e0, x0, dz0, s0);
         ref_model(r, e1, x1, dz1, s1);
         total++;
         if ({lat, o_ratio, o_div_zero, o_saturated} !== {LAT, x1, x0, dz1, dz0, s1, s0})
            $display("[TB] FAIL random%0d ref=%h err=%h_%h: got lat=%0d ratio=%h dz=%b sat=%b want lat=%0d ratio=%h dz=%b sat=%b",
                     i, r, e1, e0, lat, o_ratio, o_div_zero, o_saturated,
                     LAT, {x1, x0}, {dz1, dz0}, {s1, s0});
         else passed++;
         repeat ($urandom_range(0, 3)) @(negedge i_clock);
         releaseResult();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/monopulse_ratio.md
Name: monopulse_ratio

Overview:
- Multi-channel monopulse ratio unit: computes signed fixed-point ratio error/reference for NUM_CH error channels (e.g. azimuth, elevation) against one shared reference (sum) channel.
- Replaces the magnitude-product stage ahead of the angle-estimation logic with a true normalised ratio.
- Uses one shared sequential restoring divider that is time-multiplexed across channels.
- Has valid/ready handshakes on both sides.

Parameters:
- DATA_SIZE, 64, width of each signed input sample and each output ratio.
- FRAC_BITS, 16, fractional bits of the output ratio (Q(DATA_SIZE-FRAC_BITS).FRAC_BITS).
- NUM_CH, 2, number of error channels processed per reference sample.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  reset
- i_valid  in  1  input sample valid
- o_ready  out  1  block can accept a sample
- i_reference  in  DATA_SIZE  signed reference (sum) sample
- i_error  in  NUM_CH*DATA_SIZE  signed error samples; channel c in bits [c*DATA_SIZE +: DATA_SIZE]
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_ratio  out  NUM_CH*DATA_SIZE  signed ratios, packed like i_error
- o_div_zero  out  NUM_CH  per-channel reference-was-zero flag
- o_saturated  out  NUM_CH  per-channel saturation flag

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clock. On reset the state goes to IDLE; o_valid=0, o_ratio=0, o_div_zero=0, o_saturated=0. o_ready=1 from the first cycle after reset.
- Reset mid-operation aborts immediately. The partial result is discarded and never presented.
- States: IDLE, LOAD, DIV, STORE, DONE.
- o_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE: on i_valid&&o_ready, register |i_reference|, |i_error[c]| and their sign bits, set ch=0, go to LOAD. Without o_ready, i_valid is ignored.
- Magnitudes are unsigned DATA_SIZE bits, so |-2^(DATA_SIZE-1)| = 2^(DATA_SIZE-1) exactly (no wrap).
- LOAD: dividend = |err[ch]| << FRAC_BITS (D = DATA_SIZE+FRAC_BITS bits), remainder=0, count=D. Go to DIV.
- DIV: one restoring quotient bit per cycle, MSB first, for D cycles, then go to STORE.
- STORE, in this order:
  - If |ref|==0: div_zero[ch]=1; magnitude = 0 if |err|==0, else MAX = 2^(DATA_SIZE-1)-1; sign = sign(err).
  - Otherwise: if quotient > MAX, saturate to MAX and set saturated[ch]=1; sign = sign(err) XOR sign(ref).
  - Write ratio[ch] = sign ? -mag : mag. Saturation is symmetric, so the most negative output is -MAX.
  - Truncation is toward zero.
  - Then ch++; go to LOAD if ch<NUM_CH, else DONE.
- DONE: outputs held stable while i_ready=0. On i_ready=1, go to IDLE (o_valid low the next cycle). Flags clear at the next accept.
- Latency: accept at edge k gives o_valid high after edge k + NUM_CH*(D+2). Defaults: 2*(80+2) = 164 cycles.
- Throughput: one sample per NUM_CH*(D+2)+2 cycles, with no back-to-back overlap.
- Simultaneous i_valid and reset: reset wins and the sample is dropped.

Optional Feature:
- MONOPULSE_ROUND_EN defined:
  - DIV runs D+1 iterations, producing one extra guard quotient bit.
  - STORE adds the guard bit to the magnitude (round half away from zero), then saturates.
  - Latency per channel becomes D+3.
- Undefined: truncation toward zero, D iterations.

Decomposition:
- monopulse_pkg:
  - state enum (IDLE, LOAD, DIV, STORE, DONE)
  - function computing MAX for a given width
  - localparam helpers for D and counter width $clog2(D+2)
- Sub-module monopulse_seq_divider: unsigned restoring divider.
  - Ports: start, dividend, divisor, busy/done, quotient.
  - The top-level FSM sequences channels through it; sign, zero and saturation handling stay in the top level.

Test Plan (bench params DATA_SIZE=16, FRAC_BITS=8, NUM_CH=2, so D=24, latency 52):
1. ref=4, err0=2, err1=-3 -> ratio0=0x0080, ratio1=0xFF40, flags 0, o_valid exactly 52 cycles after accept.
2. ref=0, err0=5, err1=0 -> ratio0=0x7FFF, ratio1=0x0000, o_div_zero=2'b11, o_saturated=0.
3. ref=1, err0=200, err1=-200 -> ratio0=0x7FFF, ratio1=0x8001, o_saturated=2'b11. Separately, ref=-32768, err0=-32768 -> ratio0=0x0100.
4. Backpressure: hold i_ready=0 for 10 cycles in DONE while pulsing i_valid -> outputs stable, o_ready=0, sample ignored. Then i_ready=1 -> o_valid drops next cycle, o_ready=1.
5. Assert reset at cycle 20 of a transaction -> all outputs 0 the next cycle and no o_valid. A following transaction with ref=4, err0=2 gives 0x0080.
6. ref=3, err0=2, err1=1 -> without MONOPULSE_ROUND_EN: 0x00AA and 0x0055. With it: 0x00AB and 0x0055, latency 54.
